edge_point_sequencer: RTL and testbench
=======================================

# edge_point_sequencer

Initiator side of the Hough voting interface. Scans the grayscale frame buffer in raster order, compares each pixel against a threshold, and hands every edge pixel's (x, y) to `hough_transformer` through its start/done handshake. Sits between the frame-buffer BRAM read port and `hough_transformer`. Signals frame completion to the top-level controller.

## Interface
Parameters:
- `WIDTH`, 640, pixels per line
- `HEIGHT`, 480, lines per frame
- `PIX_W`, 8, pixel data width

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `frame_start`  in  1  one-cycle request to scan a frame; accepted only in IDLE
- `threshold`  in  PIX_W  edge threshold, sampled on the accepted `frame_start`
- `mem_addr`  out  19  frame-buffer read address, y*WIDTH + x
- `mem_data`  in  PIX_W  BRAM read data, valid one cycle after `mem_addr`
- `ht_x`  out  10  edge x to `hough_transformer`
- `ht_y`  out  9  edge y to `hough_transformer`
- `ht_start`  out  1  one-cycle pulse launching a vote
- `ht_done`  in  1  one-cycle pulse from `hough_transformer` when the vote finishes
- `busy`  out  1  high from accepted `frame_start` until `frame_done`, inclusive
- `frame_done`  out  1  one-cycle pulse at scan end
- `edge_count`  out  19  edges issued this frame; holds until next accepted `frame_start`

## Operation
- States: IDLE, FETCH, EVAL, ISSUE, WAIT_HT, DONE.
- IDLE: `frame_start`=1 -> latch threshold; clear x, y, addr, and `edge_count`; go to FETCH.
- FETCH: `mem_addr` = current addr. Go to EVAL.
- EVAL: `mem_data` >= latched threshold (unsigned) -> load `ht_x`/`ht_y` with x/y and go to ISSUE. Otherwise advance.
- ISSUE: `ht_start`=1 for this cycle only. Increment `edge_count`. Go to WAIT_HT.
- WAIT_HT: hold `ht_x`/`ht_y`. On `ht_done`=1, advance.
- Advance rules:
  - x==WIDTH-1 -> x=0, y+=1, else x+=1; addr+=1 (incremental, no multiplier).
  - On the last pixel (x==WIDTH-1, y==HEIGHT-1), go to DONE instead of FETCH.
- DONE: `frame_done`=1 for one cycle, then IDLE.
- `frame_start` outside IDLE is ignored. No queuing.
- `ht_done` is sampled only in WAIT_HT. A pulse in any other state is ignored.
- `reset_n`=0 in any state:
  - next state is IDLE;
  - all outputs and counters return to 0;
  - a pending vote is abandoned.

## Timing
- Reset values: `mem_addr`=0, `ht_x`=0, `ht_y`=0, `ht_start`=0, `busy`=0, `frame_done`=0, `edge_count`=0.
- All outputs are registered.
- Cycle numbering: `frame_start` is sampled at edge 0; FETCH for pixel 0 occupies cycle 1.
- Per-pixel cost:
  - non-edge pixel: 2 cycles (FETCH, EVAL);
  - edge pixel: 3 + k cycles, where k is the number of WAIT_HT cycles up to and including the cycle where `ht_done` is seen.
- Blank frame of N = WIDTH*HEIGHT pixels: `frame_done` high in cycle 2N+1. `busy` is high cycles 1..2N+1.
- `ht_start` is never reasserted before `ht_done` for the prior vote. At most one vote is outstanding.
- Earliest legal `ht_done`: the cycle after `ht_start`.

## Structure
- Shared package `hough_pkg` holds:
  - IMG_WIDTH=640, IMG_HEIGHT=480;
  - X_W=10, Y_W=9, ADDR_W=19;
  - the state enum for this block.
- `hough_transformer` uses the same X_W/Y_W.
- One sub-module, `raster_counter`:
  - x/y/addr registers;
  - inputs `clear` and `advance`;
  - output `last` (x==WIDTH-1 && y==HEIGHT-1).
- The FSM, threshold compare, and handshake stay in `edge_point_sequencer`.

## Test plan
Bench conditions: WIDTH=4, HEIGHT=3, threshold=0x80. BRAM model has 1-cycle latency. Responder model pulses `ht_done` 3 cycles after `ht_start` unless noted.

- All pixels 0x00 -> no `ht_start`; `frame_done` in cycle 25; `edge_count`=0; `busy` high cycles 1..25.
- Single pixel 0x80 at (3,1) -> exactly one `ht_start` with `ht_x`=3, `ht_y`=1, `mem_addr` 7 preceding it.
  - `frame_done` in cycle 29.
  - `edge_count`=1.
  - Pixel 0x7F elsewhere must not trigger.
- All pixels 0xFF -> 12 votes in raster order (0,0),(1,0)…(3,2); `ht_x`/`ht_y` stable through each WAIT_HT; `edge_count`=12.
- `frame_start` pulsed mid-scan, and a spurious `ht_done` pulsed during FETCH -> both ignored; vote sequence and `frame_done` timing are unchanged.
- `reset_n`=0 for 1 cycle during WAIT_HT of the second vote -> next cycle all outputs are 0 and the state is IDLE.
  - A following `frame_start` rescans from (0,0).
- Responder delays `ht_done` by 50 cycles -> `ht_start` stays low and `mem_addr` frozen until `ht_done`; then FETCH of the next address.

Source files
------------

// File: rtl/hough_pkg.sv
// hough_pkg
// Shared definitions for the Hough voting path: default image geometry,
// coordinate/address widths (also used by hough_transformer) and the
// state encoding of edge_point_sequencer.
package hough_pkg;

    localparam int IMG_WIDTH  = 640;
    localparam int IMG_HEIGHT = 480;

    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int ADDR_W = 19;

    // edge_point_sequencer scan states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EVAL    = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT_HT = 3'd4,
        S_DONE    = 3'd5
    } eps_state_t;

endpackage

// File: rtl/raster_counter.sv
// raster_counter
// Raster-order pixel position tracker. Keeps x, y and the linear frame
// buffer address in step; the address is advanced incrementally so no
// multiplier is needed.
//
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset, clears all registers
//   clear    restart at pixel (0,0), address 0
//   advance  step to the next pixel in raster order
//   x, y     current pixel coordinates
//   addr     current linear address (y*WIDTH + x)
//   last     current pixel is the final pixel of the frame
module raster_counter
    import hough_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic end_of_line;

    assign end_of_line = (x == X_W'(WIDTH - 1));
    assign last        = end_of_line && (y == Y_W'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            if (end_of_line) begin
                x <= '0;
                y <= y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/edge_point_sequencer.sv
// edge_point_sequencer
// Scans the frame buffer in raster order, thresholds each pixel and hands
// every edge pixel's (x, y) to hough_transformer, one vote at a time.
//
// Handshake: ht_start is a one-cycle pulse carrying ht_x/ht_y; the
// coordinates stay stable until hough_transformer answers with a
// one-cycle ht_done, which is only looked at while waiting for it. At
// most one vote is outstanding.
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   frame_start    scan request, accepted in IDLE only
//   threshold      edge threshold, captured with an accepted frame_start
//   mem_addr       frame buffer read address (data returns one cycle later)
//   mem_data       frame buffer read data
//   ht_x, ht_y     edge coordinates for the current vote
//   ht_start       vote launch pulse
//   ht_done        vote completion pulse
//   busy           scan in progress, through the frame_done cycle
//   frame_done     one-cycle end-of-scan pulse
//   edge_count     votes issued in the current/last frame
//   dbg_state      current FSM state
module edge_point_sequencer
    import hough_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [PIX_W-1:0]  threshold,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [X_W-1:0]    ht_x,
    output logic [Y_W-1:0]    ht_y,
    output logic              ht_start,
    input  logic              ht_done,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] edge_count,
    output logic [2:0]        dbg_state
);

    eps_state_t        state, next_state;
    logic [PIX_W-1:0]  thr_q;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_last;
    logic              is_edge;
    logic              clear;
    logic              advance;

    // mem_data is only meaningful in EVAL, one cycle after FETCH drove the address
    assign is_edge = (mem_data >= thr_q);
    assign clear   = (state == S_IDLE) && frame_start;
    // The final pixel never advances, so the counter parks on it after a scan
    assign advance = (((state == S_EVAL) && !is_edge) ||
                      ((state == S_WAIT_HT) && ht_done)) && !cur_last;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .advance (advance),
        .x       (cur_x),
        .y       (cur_y),
        .addr    (cur_addr),
        .last    (cur_last)
    );

    // The counter address is already a register and only moves on advance,
    // so it holds through EVAL/ISSUE/WAIT_HT
    assign mem_addr  = cur_addr;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (frame_start) next_state = S_FETCH;
            S_FETCH:   next_state = S_EVAL;
            S_EVAL: begin
                if (is_edge)       next_state = S_ISSUE;
                else if (cur_last) next_state = S_DONE;
                else               next_state = S_FETCH;
            end
            S_ISSUE:   next_state = S_WAIT_HT;
            S_WAIT_HT: if (ht_done) next_state = cur_last ? S_DONE : S_FETCH;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Status outputs are decoded from next_state so they are registered
    // yet line up with the state they describe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            thr_q      <= '0;
            ht_x       <= '0;
            ht_y       <= '0;
            ht_start   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            edge_count <= '0;
        end else begin
            ht_start   <= (next_state == S_ISSUE);
            frame_done <= (next_state == S_DONE);
            busy       <= (next_state != S_IDLE);
            if (clear) begin
                thr_q      <= threshold;
                edge_count <= '0;
            end
            if ((state == S_EVAL) && is_edge) begin
                ht_x <= cur_x;
                ht_y <= cur_y;
            end
            if (state == S_ISSUE) edge_count <= edge_count + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_edge_point_sequencer.sv
// tb_edge_point_sequencer
// Directed bench for edge_point_sequencer on a 4x3 frame, threshold 0x80,
// with a 1-cycle-latency frame buffer model and an ht_done responder.
module tb_edge_point_sequencer;
  import hough_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
  localparam int NPIX = W * H;
  localparam logic [7:0] THR = 8'h80;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              frame_start = 1'b0;
  logic [7:0]        threshold = 8'h00;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;
  logic [X_W-1:0]    ht_x;
  logic [Y_W-1:0]    ht_y;
  logic              ht_start;
  logic              ht_done = 1'b0;
  logic              busy;
  logic              frame_done;
  logic [ADDR_W-1:0] edge_count;
  logic [2:0]        dbg_state;

  edge_point_sequencer #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .threshold  (threshold),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .ht_x       (ht_x),
    .ht_y       (ht_y),
    .ht_start   (ht_start),
    .ht_done    (ht_done),
    .busy       (busy),
    .frame_done (frame_done),
    .edge_count (edge_count),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // cycle counter, stable at negedge
  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  // frame buffer model
  logic [7:0] img [16];
  always @(posedge clk) mem_data <= img[mem_addr[3:0]];

  // responder: ht_done during cycle (ht_start cycle + resp_delay)
  int resp_delay = 3;
  int due = -1;
  int spur_at = -1;
  always @(negedge clk) if (ht_start === 1'b1) due = tick + resp_delay;
  always @(posedge clk) begin
    #1;
    ht_done = (tick == due) || (tick == spur_at);
  end

  // scoreboard and monitor
  logic [X_W+Y_W-1:0] exp_q[$];
  bit mon_en = 1'b0;
  bit waiting = 1'b0;
  bit post_done = 1'b0;
  logic [ADDR_W-1:0] w_addr;
  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;
  int vote_cnt = 0;
  int busy_cnt = 0;
  int done_seen = 0;
  int done_tick = 0;
  int base = 0;

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (busy) busy_cnt++;
      if (frame_done) begin
        done_seen++;
        done_tick = tick;
      end
      if (tick == spur_at) check("spur_in_fetch", dbg_state, S_FETCH);
      if (post_done) begin
        post_done = 1'b0;
        if (w_addr != ADDR_W'(NPIX - 1)) begin
          check("next_fetch_addr", mem_addr, w_addr + 1);
          check("next_fetch_state", dbg_state, S_FETCH);
        end
      end
      if (waiting) begin
        check("wait_no_start", ht_start, 0);
        check("wait_addr_frozen", mem_addr, w_addr);
        check("wait_x_stable", ht_x, w_x);
        check("wait_y_stable", ht_y, w_y);
        if (ht_done) begin
          waiting = 1'b0;
          post_done = 1'b1;
        end
      end else if (ht_start) begin
        logic [X_W+Y_W-1:0] e;
        vote_cnt++;
        if (exp_q.size() == 0) begin
          check("vote_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("vote_x", ht_x, e[X_W-1:0]);
          check("vote_y", ht_y, e[X_W+Y_W-1:X_W]);
          check("vote_addr", mem_addr, ADDR_W'(e[X_W+Y_W-1:X_W]) * W + ADDR_W'(e[X_W-1:0]));
        end
        waiting = 1'b1;
        w_addr = mem_addr;
        w_x = ht_x;
        w_y = ht_y;
      end
    end
  end

  task automatic fill_img(input logic [7:0] v);
    for (int i = 0; i < 16; i++) img[i] = v;
  endtask

  // one scan: push expected votes, start, optionally pulse frame_start at
  // frame cycle fs_rel and a spurious ht_done at frame cycle spur_rel
  task automatic run_frame(input string tag, input int dly, input int fs_rel, input int spur_rel);
    int exp_done;
    int exp_edges;
    int budget;
    exp_done = 1;
    exp_edges = 0;
    resp_delay = dly;
    vote_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (img[i] >= THR) begin
        exp_q.push_back({Y_W'(i / W), X_W'(i % W)});
        exp_done += 3 + dly;
        exp_edges++;
      end else begin
        exp_done += 2;
      end
    end
    @(negedge clk); #1;
    frame_start = 1'b1;
    threshold = THR;
    base = tick;
    busy_cnt = 0;
    done_seen = 0;
    done_tick = 0;
    spur_at = (spur_rel >= 0) ? base + spur_rel : -1;
    budget = 0;
    while (done_seen == 0 && budget < 2000) begin
      @(negedge clk); #1;
      threshold = 8'hFF;
      frame_start = ((tick - base) == fs_rel);
      budget++;
    end
    frame_start = 1'b0;
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_done_cycle"}, done_tick - base, exp_done);
    check({tag, "_busy_cycles"}, busy_cnt, exp_done);
    check({tag, "_edge_count"}, edge_count, exp_edges);
    check({tag, "_votes"}, vote_cnt, exp_edges);
    @(negedge clk); #1;
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_done_pulse"}, frame_done, 0);
    check({tag, "_idle"}, dbg_state, S_IDLE);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
    spur_at = -1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_x"}, ht_x, 0);
    check({tag, "_y"}, ht_y, 0);
    check({tag, "_start"}, ht_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fdone"}, frame_done, 0);
    check({tag, "_ecount"}, edge_count, 0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  initial begin
    int budget;
    fill_img(8'h00);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    mon_en = 1'b1;

    // blank frame
    fill_img(8'h00);
    run_frame("blank", 3, -1, -1);

    // single edge at (3,1), 0x7F elsewhere
    fill_img(8'h7F);
    img[7] = 8'h80;
    run_frame("single", 3, -1, -1);

    // every pixel an edge
    fill_img(8'hFF);
    run_frame("full", 3, -1, -1);

    // ignored frame_start mid-scan and spurious ht_done in FETCH of pixel 2
    fill_img(8'hFF);
    run_frame("ignore", 3, 19, 13);

    // reset during WAIT_HT of the second vote
    fill_img(8'hFF);
    resp_delay = 3;
    vote_cnt = 0;
    for (int i = 0; i < NPIX; i++) exp_q.push_back({Y_W'(i / W), X_W'(i % W)});
    @(negedge clk); #1;
    frame_start = 1'b1;
    threshold = THR;
    @(negedge clk); #1;
    frame_start = 1'b0;
    budget = 0;
    while (vote_cnt < 2 && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    check("abort_two_votes", vote_cnt, 2);
    @(negedge clk); #1;
    check("abort_in_wait", dbg_state, S_WAIT_HT);
    mon_en = 1'b0;
    reset_n = 1'b0;
    @(negedge clk); #1;
    check_zero("abort");
    reset_n = 1'b1;
    exp_q.delete();
    due = -1;
    waiting = 1'b0;
    post_done = 1'b0;
    mon_en = 1'b1;
    run_frame("rescan", 3, -1, -1);

    // slow responder
    fill_img(8'h00);
    img[7] = 8'hFF;
    run_frame("slow", 50, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
